// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use stalls, branch flushes,
// E-stage forwarding and a data-memory wait/timeout FSM. Define HAZARD_PERF_EN for perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        ResultSrcE0,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    input  logic        FaultAck,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
`ifdef HAZARD_PERF_EN
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount,
`endif
    output logic        MemFault
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic       mem_wait;
    logic       lw_stall;
    logic       freeze;
    logic       run_rules;
    logic       branch_flush;
    logic       load_stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // M-stage results are newer than W-stage results, so M wins on a double match.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            fwd_a = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            fwd_a = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            fwd_b = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            fwd_b = 2'b01;
    end

    // A freeze beats a branch flush, which in turn kills any load-use stall of the dead D instruction.
    always_comb begin
        mem_wait  = MemReqM & ~MemReadyM;
        lw_stall  = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
        freeze    = 1'b0;
        run_rules = 1'b0;
        case (state)
            RUN: begin
                freeze    = mem_wait;
                run_rules = ~mem_wait;
            end
            MEM_WAIT: begin
                freeze    = ~MemReadyM;
                run_rules = MemReadyM;
            end
            default: begin
                freeze    = 1'b0;
                run_rules = 1'b0;
            end
        endcase
        branch_flush = run_rules & PCSrcE;
        load_stall   = run_rules & ~PCSrcE & lw_stall;
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        MemFault  = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (state == FAULT) begin
                // Drain: fetch held, D/E/M bubbled, W allowed to retire.
                MemFault = 1'b1;
                StallF   = 1'b1;
                FlushD   = 1'b1;
                FlushE   = 1'b1;
                FlushM   = 1'b1;
            end else if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else if (branch_flush) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                FAULT: begin
                    if (FaultAck) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCycles <= 32'd0;
            FlushCount  <= 32'd0;
        end else begin
            if (StallF)
                StallCycles <= StallCycles + 32'd1;
            if (branch_flush)
                FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
- Sequences the decode and execute stages: load-use stalls, branch/jump flushes, forwarding selects for E-stage operands.
- Adds a data-memory wait FSM with a timeout/fault path that freezes or drains the pipeline.
- Sits beside decode; consumes decode's Rs1D/Rs2D and downstream pipeline register fields.

Parameters:
- MEM_TIMEOUT, 16, cycles a pending M-stage access may wait for ready before fault (legal range 2..255).
- CNT_W, 8, width of the wait counter (must hold MEM_TIMEOUT-1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- Rs1D, Rs2D  in  5 each  source regs of instruction in D
- Rs1E, Rs2E  in  5 each  source regs of instruction in E
- RdE, RdM, RdW  in  5 each  destination regs in E/M/W
- ResultSrcE0  in  1  E instruction is a load
- RegWriteM, RegWriteW  in  1 each  M/W instructions write the register file
- PCSrcE  in  1  taken branch or jump resolved in E
- MemReqM  in  1  M instruction accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- FaultAck  in  1  trap logic acknowledges memory fault
- StallF, StallD, StallE, StallM, StallW  out  1 each  hold the stage's pipeline register
- FlushD, FlushE, FlushM  out  1 each  load a bubble into the stage register
- ForwardAE, ForwardBE  out  2 each  E operand select: 00 regfile, 01 W result, 10 M ALU result
- MemFault  out  1  memory timeout fault, level

Behaviour:
- FSM states: RUN, MEM_WAIT, FAULT. State and wait counter are registered; all other outputs are combinational from state and inputs.
- While rst_n is low at a clock edge: state <= RUN, counter <= 0.
- Output values with rst_n low: all Stall* = 0, FlushD/E/M = 1, Forward* = 00, MemFault = 0.
- Forwarding (all states):
  - ForwardAE = 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Otherwise 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Otherwise 00.
  - ForwardBE is identical using Rs2E. M takes priority over W.
- lwStall = ResultSrcE0 & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).
- memWait = MemReqM & !MemReadyM.
- RUN:
  - If memWait: all five Stall* = 1, no flushes. This is a global freeze that overrides lwStall and PCSrcE. Next state MEM_WAIT, counter <= 1.
  - Else if PCSrcE: FlushD = FlushE = 1, no stall. lwStall is suppressed because the D instruction is dead.
  - Else if lwStall: StallF = StallD = 1, FlushE = 1.
  - Else all 0.
- MEM_WAIT:
  - If MemReadyM: apply the RUN rules for that cycle, treating memWait as 0. Next state RUN, counter <= 0.
  - Else if counter == MEM_TIMEOUT-1: global freeze this cycle; next state FAULT.
  - Else: global freeze, counter <= counter+1.
- FAULT:
  - MemFault = 1, StallF = 1, FlushD = FlushE = FlushM = 1, StallW = 0.
  - Stays in FAULT until FaultAck = 1; next state RUN, counter <= 0.
  - MemReqM and MemReadyM are ignored in FAULT.
- Latency:
  - All stall, flush and forward decisions apply in the same cycle as their inputs.
  - Entry to MEM_WAIT takes effect at the next edge.
  - MemFault asserts MEM_TIMEOUT cycles after the first unready request cycle.
- Simultaneous events:
  - Global freeze beats PCSrcE, and PCSrcE beats lwStall.
  - FaultAck in RUN or MEM_WAIT is ignored.
  - Reset mid-MEM_WAIT or mid-FAULT returns to RUN with MemFault = 0 in the reset cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs StallCycles[31:0] and FlushCount[31:0], both reset to 0.
  - StallCycles increments each cycle StallF = 1 (outside reset).
  - FlushCount increments each cycle FlushE = 1 in RUN due to PCSrcE.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ResultSrcE0 = 1, RdE = 5, Rs1D = 5 -> StallF = StallD = 1, FlushE = 1, for one cycle only. With RdE = 0 -> no stall.
- Forwarding:
  - RegWriteM = 1, RdM = 3, RegWriteW = 1, RdW = 3, Rs1E = 3 -> ForwardAE = 10.
  - Drop RegWriteM -> ForwardAE = 01.
  - Rs2E = 0 with RdM = 0 -> ForwardBE = 00.
- Branch vs load-use: PCSrcE = 1 and lwStall = 1 in the same cycle -> FlushD = FlushE = 1, StallF = StallD = 0.
- Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles then 1 -> all Stall* = 1 for 3 cycles, release on the 4th, state RUN, MemFault never set.
- Timeout: MEM_TIMEOUT = 4, MemReadyM held 0 -> MemFault = 1 from cycle 4. Flushes held until FaultAck pulse, then MemFault = 0 the next cycle.
- Reset mid-FAULT: assert rst_n = 0 for 1 cycle -> MemFault = 0, FlushD/E/M = 1 during reset, state RUN after. With HAZARD_PERF_EN, both counters read 0.
